// File: rtl/cpu5_seq_ctrl_pkg.sv
// rtl/cpu5_seq_ctrl_pkg.sv - shared encodings for the cpu5 multi-cycle sequencer
package cpu5_seq_ctrl_pkg;

  localparam int CPU5_STATE_SIZE = 3;

  typedef enum logic [CPU5_STATE_SIZE-1:0] {
    CPU5_ST_IDLE   = 3'd0,
    CPU5_ST_FETCH  = 3'd1,
    CPU5_ST_DECODE = 3'd2,
    CPU5_ST_EXEC   = 3'd3,
    CPU5_ST_MEM    = 3'd4,
    CPU5_ST_WB     = 3'd5,
    CPU5_ST_HALT   = 3'd6
  } cpu5_state_e;

  localparam logic [1:0] CPU5_PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] CPU5_PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] CPU5_PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CPU5_FAULT_NONE    = 2'b00;
  localparam logic [1:0] CPU5_FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] CPU5_FAULT_TIMEOUT = 2'b10;

  function automatic logic cpu5_is_mem_state(input cpu5_state_e st);
    return (st == CPU5_ST_FETCH) || (st == CPU5_ST_MEM);
  endfunction

endpackage

// File: rtl/cpu5_seq_timer.sv
// rtl/cpu5_seq_timer.sv - memory wait counter with limit compare
module cpu5_seq_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      r_cnt <= 8'd0;
    end else if (inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Fires on the wait cycle that brings the count up to LIMIT.
  assign expired = inc && (r_cnt == LAST);

endmodule

// File: rtl/cpu5_seq_ctrl.sv
// rtl/cpu5_seq_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with shared memory port
module cpu5_seq_ctrl
  import cpu5_seq_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             run,
  input  logic             dec_memtoreg,
  input  logic             dec_memwrite,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_regwrite,
  input  logic             dec_illegal,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code
);

  cpu5_state_e      r_state;
  cpu5_state_e      w_next;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       r_fault_code;
  logic             w_fault_set;
  logic [1:0]       w_fault_code;
  logic             w_expired;
  logic             w_tmr_clr;
  logic             w_tmr_inc;

  assign mem_req      = cpu5_is_mem_state(r_state);
  assign mem_addr_sel = (r_state == CPU5_ST_MEM);
  assign mem_we       = (r_state == CPU5_ST_MEM) && dec_memwrite;
  assign wb_sel       = (r_state == CPU5_ST_WB) && dec_memtoreg;
  assign fault        = (r_state == CPU5_ST_HALT);
  assign fault_code   = r_fault_code;
  assign state        = r_state;
  assign instret      = r_instret;

  // Any completed access ends the wait, so the next access starts from zero.
  assign w_tmr_clr = !mem_req || mem_ack;
  assign w_tmr_inc = mem_req && !mem_ack;

  cpu5_seq_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_tmr_clr),
    .inc    (w_tmr_inc),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= CPU5_ST_IDLE;
      r_instret    <= '0;
      r_fault_code <= CPU5_FAULT_NONE;
    end else begin
      r_state <= w_next;
      if (retire) begin
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_fault_set) begin
        r_fault_code <= w_fault_code;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = CPU5_PCSRC_SEQ;
    rf_we        = 1'b0;
    retire       = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_code = CPU5_FAULT_NONE;

    case (r_state)
      CPU5_ST_IDLE: begin
        if (run) w_next = CPU5_ST_FETCH;
      end
      CPU5_ST_FETCH: begin
        if (mem_ack) begin
          ir_we  = 1'b1;
          w_next = CPU5_ST_DECODE;
        end else if (w_expired) begin
          w_next       = CPU5_ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = CPU5_FAULT_TIMEOUT;
        end
      end
      CPU5_ST_DECODE: begin
        if (dec_illegal) begin
          w_next       = CPU5_ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = CPU5_FAULT_ILLEGAL;
        end else begin
          w_next = CPU5_ST_EXEC;
        end
      end
      CPU5_ST_EXEC: begin
        if (dec_jump) begin
          pc_we  = 1'b1;
          pc_src = CPU5_PCSRC_JUMP;
          retire = 1'b1;
        end else if (dec_branch) begin
          pc_we  = 1'b1;
          pc_src = alu_zero ? CPU5_PCSRC_BRANCH : CPU5_PCSRC_SEQ;
          retire = 1'b1;
        end else if (dec_memtoreg || dec_memwrite) begin
          w_next = CPU5_ST_MEM;
        end else if (dec_regwrite) begin
          w_next = CPU5_ST_WB;
        end else begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      CPU5_ST_MEM: begin
        if (mem_ack) begin
          if (dec_memtoreg) begin
            w_next = CPU5_ST_WB;
          end else begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end else if (w_expired) begin
          w_next       = CPU5_ST_HALT;
          w_fault_set  = 1'b1;
          w_fault_code = CPU5_FAULT_TIMEOUT;
        end
      end
      CPU5_ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      CPU5_ST_HALT: begin
        w_next = CPU5_ST_HALT;
      end
      default: begin
        w_next = CPU5_ST_IDLE;
      end
    endcase

    // run is only sampled here and in IDLE.
    if (retire) begin
      w_next = run ? CPU5_ST_FETCH : CPU5_ST_IDLE;
    end
  end

endmodule

// File: tb/tb_cpu5_seq_ctrl.sv
// tb/tb_cpu5_seq_ctrl.sv - directed scoreboard bench for cpu5_seq_ctrl
module tb_cpu5_seq_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic             run;
  logic             dec_memtoreg, dec_memwrite, dec_branch, dec_jump, dec_regwrite, dec_illegal;
  logic             alu_zero;
  logic             mem_ack;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, wb_sel, retire;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;
  logic             fault;
  logic [1:0]       fault_code;

  int total = 0;
  int bad   = 0;
  logic [13:0] sb_q[$];

  cpu5_seq_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .dec_memtoreg(dec_memtoreg),
    .dec_memwrite(dec_memwrite),
    .dec_branch  (dec_branch),
    .dec_jump    (dec_jump),
    .dec_regwrite(dec_regwrite),
    .dec_illegal (dec_illegal),
    .alu_zero    (alu_zero),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .retire      (retire),
    .instret     (instret),
    .state       (state),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  wire [13:0] w_obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, rf_we, wb_sel, retire};

  function automatic logic [13:0] ex(input logic [2:0] st, input logic req, input logic we,
                                     input logic asel, input logic irwe, input logic pcwe,
                                     input logic [1:0] ps, input logic rfwe, input logic wbs,
                                     input logic ret);
    return {st, req, we, asel, irwe, pcwe, ps, rfwe, wbs, ret};
  endfunction

  function automatic logic [13:0] e_idle();          return ex(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); endfunction
  function automatic logic [13:0] e_fetch(input logic a); return ex(3'd1, 1, 0, 0, a, 0, 2'b00, 0, 0, 0); endfunction
  function automatic logic [13:0] e_dec();           return ex(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); endfunction
  function automatic logic [13:0] e_exec();          return ex(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); endfunction
  function automatic logic [13:0] e_exret(input logic [1:0] ps); return ex(3'd3, 0, 0, 0, 0, 1, ps, 0, 0, 1); endfunction
  function automatic logic [13:0] e_mem(input logic we, input logic ret); return ex(3'd4, 1, we, 1, 0, ret, 2'b00, 0, 0, ret); endfunction
  function automatic logic [13:0] e_wb(input logic wbs); return ex(3'd5, 0, 0, 0, 0, 1, 2'b00, 1, wbs, 1); endfunction
  function automatic logic [13:0] e_halt();          return ex(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: expectation queued with the stimulus, compared on the falling edge.
  task automatic cyc(input string tag, input logic [13:0] exp);
    logic [13:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    chk(tag, 32'(w_obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    resetn = 0; run = 0; alu_zero = 0; mem_ack = 0;
    dec_memtoreg = 0; dec_memwrite = 0; dec_branch = 0; dec_jump = 0; dec_regwrite = 0; dec_illegal = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_obs", 32'(w_obs), 32'(e_idle()));
    chk("rst_instret", instret, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    resetn = 1;
    cyc("idle_norun", e_idle());

    // R-type, zero-wait memory
    run = 1; dec_regwrite = 1; mem_ack = 1;
    cyc("r_idle", e_idle());
    cyc("r_fetch", e_fetch(1));
    cyc("r_dec", e_dec());
    cyc("r_exec", e_exec());
    cyc("r_wb", e_wb(0));
    chk("r_instret", instret, 32'd1);

    // lw with 3 wait cycles in MEM
    dec_memtoreg = 1;
    cyc("lw_fetch", e_fetch(1));
    mem_ack = 0;
    cyc("lw_dec", e_dec());
    cyc("lw_exec", e_exec());
    for (int i = 0; i < 3; i++) cyc("lw_memwait", e_mem(0, 0));
    mem_ack = 1;
    cyc("lw_memack", e_mem(0, 0));
    cyc("lw_wb", e_wb(1));
    chk("lw_instret", instret, 32'd2);

    // branches taken / not taken, then jump with branch also set
    dec_memtoreg = 0; dec_regwrite = 0; dec_branch = 1; alu_zero = 1;
    cyc("bt_fetch", e_fetch(1));
    cyc("bt_dec", e_dec());
    cyc("bt_exec", e_exret(2'b01));
    alu_zero = 0;
    cyc("bn_fetch", e_fetch(1));
    cyc("bn_dec", e_dec());
    cyc("bn_exec", e_exret(2'b00));
    dec_jump = 1; alu_zero = 1;
    cyc("j_fetch", e_fetch(1));
    cyc("j_dec", e_dec());
    cyc("j_exec", e_exret(2'b10));
    chk("bj_instret", instret, 32'd5);

    // sw, run dropped during MEM
    dec_jump = 0; dec_branch = 0; dec_memwrite = 1;
    cyc("sw_fetch", e_fetch(1));
    mem_ack = 0;
    cyc("sw_dec", e_dec());
    cyc("sw_exec", e_exec());
    cyc("sw_memwait", e_mem(1, 0));
    run = 0; mem_ack = 1;
    cyc("sw_memack", e_mem(1, 1));
    mem_ack = 0;
    cyc("sw_idle1", e_idle());
    cyc("sw_idle2", e_idle());
    chk("sw_instret", instret, 32'd6);

    // ack arriving on the limit cycle wins, then illegal opcode
    dec_memwrite = 0; dec_illegal = 1; run = 1;
    cyc("il_idle", e_idle());
    for (int i = 0; i < 3; i++) cyc("il_fetchwait", e_fetch(0));
    mem_ack = 1;
    cyc("il_fetch_lim_ack", e_fetch(1));
    mem_ack = 0;
    cyc("il_dec", e_dec());
    cyc("il_halt", e_halt());
    chk("il_fault", 32'(fault), 32'd1);
    chk("il_code", 32'(fault_code), 32'd1);
    chk("il_instret", instret, 32'd6);

    resetn = 0; dec_illegal = 0; run = 0;
    @(posedge clk);
    #1;
    chk("rst2_obs", 32'(w_obs), 32'(e_idle()));
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_code", 32'(fault_code), 32'd0);
    chk("rst2_instret", instret, 32'd0);

    // FETCH timeout after 4 wait cycles
    resetn = 1; run = 1;
    cyc("to_idle", e_idle());
    for (int i = 0; i < 4; i++) cyc("to_fetchwait", e_fetch(0));
    cyc("to_halt", e_halt());
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd2);
    mem_ack = 1;
    cyc("to_halt_ack", e_halt());
    chk("to_code_hold", 32'(fault_code), 32'd2);
    resetn = 0; mem_ack = 0;
    @(posedge clk);
    #1;
    chk("rst3_obs", 32'(w_obs), 32'(e_idle()));
    chk("rst3_fault", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu5_seq_ctrl.md
# cpu5_seq_ctrl

Multi-cycle sequencer for the cpu5 core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and shares the single memory port between instruction fetch and load/store. It turns the main decoder's static control bits into per-cycle datapath enables. It sits between the main decoder outputs and the datapath registers: PC, IR, register file and memory port.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: cycles without mem_ack before a fault; range 1..255.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; single clock domain.
- resetn  in  1  reset, synchronous, active-low.
- run  in  1  level; 1 = keep issuing instructions.
- dec_memtoreg, dec_memwrite, dec_branch, dec_jump, dec_regwrite  in  1 each  main decoder outputs.
- dec_illegal  in  1  opcode not recognised by the decoder.
- alu_zero  in  1  branch condition from the ALU.
- mem_ack  in  1  memory port completion.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- pc_src  out  2  next-PC source: 00 = pc+4, 01 = branch target, 10 = jump target.
- rf_we  out  1  register-file write.
- wb_sel  out  1  write-back data: 0 = ALU, 1 = memory.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- state  out  3  current state, for debug.
- fault  out  1  sticky error flag.
- fault_code  out  2  01 = illegal opcode, 10 = memory timeout.

## Operation
States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.

Transitions and per-state outputs:
- IDLE: if run, go to FETCH. No outputs asserted.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. On mem_ack: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: the dec_* inputs are valid from this state until the instruction retires. If dec_illegal, go to HALT with fault_code 01. Otherwise go to EXEC.
- EXEC, checked in priority order:
  - dec_jump: pc_we=1, pc_src=10, retire.
  - dec_branch: pc_we=1, pc_src = alu_zero ? 01 : 00, retire.
  - dec_memtoreg or dec_memwrite: go to MEM.
  - dec_regwrite: go to WB.
  - otherwise: pc_we=1, pc_src=00, retire.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=dec_memwrite. On mem_ack:
  - if dec_memtoreg, go to WB;
  - otherwise pc_we=1, pc_src=00, retire.
- WB: rf_we=1, wb_sel=dec_memtoreg, pc_we=1, pc_src=00, retire.
- Retire: assert retire for one cycle, increment instret (wraps at 2^CNT_W), then go to FETCH if run, else IDLE.
- HALT: terminal; all enables 0, fault=1. Only resetn leaves HALT.

Handshake rules:
- mem_req, mem_we and mem_addr_sel are functions of state only. They stay stable from request until the cycle mem_ack is seen.
- mem_ack outside FETCH/MEM is ignored.

Timeout:
- An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ack=0.
- When it reaches MEM_TIMEOUT, go to HALT with fault_code 10.
- If mem_ack arrives in the same cycle the limit is reached, mem_ack wins.

## Timing
- Reset (resetn=0 at a clk edge): state=IDLE, all outputs 0, instret=0, fault=0, fault_code=00, wait counter=0.
- Reset mid-instruction: abandons the instruction at the next edge; mem_req drops after that edge.
- ir_we, pc_we, pc_src, rf_we and retire are combinational and may depend on mem_ack and alu_zero within the cycle. All other outputs are decoded from registered state.
- Latency with a zero-wait memory (mem_ack in the first FETCH/MEM cycle):
  - R-type (regwrite): 4 cycles, FETCH-DECODE-EXEC-WB.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump: 3 cycles.
  - Each memory wait cycle adds 1.
- run deasserted mid-instruction: the instruction completes and retires, then the FSM enters IDLE. run is sampled only at retire and in IDLE.
- From IDLE with run=1: FETCH begins on the next cycle.

## Structure
- Shared package: the state encodings (CPU5_ST_*), pc_src encodings (CPU5_PCSRC_*), fault codes, and a CPU5_STATE_SIZE width define, all added to defines.v.
- One natural sub-module, cpu5_seq_timer: the wait counter plus limit compare, with inputs clr and inc and output expired.
- The FSM, output decode and instret counter stay in cpu5_seq_ctrl.

## Test plan
- Reset then run=1, R-type decode (regwrite=1), mem_ack held high -> states 1,2,3,5; rf_we=1 and retire in cycle 4; instret=1.
- lw (memtoreg=1, regwrite=1) with mem_ack delayed 3 cycles in MEM -> mem_req=1, mem_addr_sel=1 held 4 cycles; WB asserts wb_sel=1; total 8 cycles.
- Branch with alu_zero=1, then with alu_zero=0 -> pc_src=01, then 00; pc_we=1 in EXEC; 3 cycles each.
- sw with run dropped during MEM -> mem_we=1; retire; state returns to IDLE (0); no further FETCH.
- mem_ack never asserted in FETCH, MEM_TIMEOUT=4 -> HALT after 4 wait cycles; fault=1, fault_code=10; a later mem_ack is ignored; resetn=0 clears to IDLE.
- dec_illegal=1 in DECODE -> HALT with fault_code=01; no pc_we, rf_we or retire; instret unchanged.
